// File: rtl/keypad_lock_ctrl.sv
// keypad_lock_ctrl
//   Keypad door lock controller. Collects a password digit by digit, checks it
//   on an enter strobe, opens the door for a timed window on a match, counts
//   consecutive failures and raises a timed alarm lockout after MAX_TRIES.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   digit_valid  in   strobe: digit is valid
//   digit        in   [DIGIT_W] keypad digit
//   enter        in   strobe: submit current entry
//   clear        in   strobe: discard current entry
//   prog_req     in   strobe: request password change (PW_PROG_EN builds only)
//   access       out  door unlock, high while open
//   alram        out  alarm, high during lockout
//   locked       out  keypad locked out
//   count        out  [CNT_W] consecutive failed attempts
//   entry_len    out  [LEN_W] digits buffered, saturates at PW_DIGITS
//
// Build option
//   PW_PROG_EN   adds the PROG state: prog_req while open lets a new password
//                be entered. Without it the password is the constant DEFAULT_PW.
module keypad_lock_ctrl #(
  parameter int DIGIT_W     = 4,
  parameter int PW_DIGITS   = 4,
  parameter logic [PW_DIGITS*DIGIT_W-1:0] DEFAULT_PW = 16'h1234,
  parameter int MAX_TRIES   = 3,
  parameter int OPEN_CYC    = 100,
  parameter int LOCKOUT_CYC = 1000,
  localparam int CNT_W      = $clog2(MAX_TRIES + 1),
  localparam int LEN_W      = $clog2(PW_DIGITS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               enter,
  input  logic               clear,
  input  logic               prog_req,
  output logic               access,
  output logic               alram,
  output logic               locked,
  output logic [CNT_W-1:0]   count,
  output logic [LEN_W-1:0]   entry_len
);

  localparam int PW_W    = PW_DIGITS * DIGIT_W;
  localparam int TMR_MAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OPEN,
`ifdef PW_PROG_EN
    S_PROG,
`endif
    S_LOCKOUT
  } state_t;

  state_t             state_q, state_d;
  logic [PW_W-1:0]    buf_q, buf_d;
  logic [LEN_W-1:0]   entry_len_q, entry_len_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               access_q, access_d;
  logic               alram_q, alram_d;
  logic               locked_q, locked_d;
  logic [PW_W-1:0]    pw_cur;

`ifdef PW_PROG_EN
  logic [PW_W-1:0]    pw_q, pw_d;
  assign pw_cur = pw_q;
`else
  logic               unused_prog_req;
  assign pw_cur          = DEFAULT_PW;
  assign unused_prog_req = prog_req;
`endif

  logic len_full;
  logic entry_ok;
  logic match;

  assign len_full = (entry_len_q == LEN_W'(PW_DIGITS));
  // A complete, non-overflowed entry; also the condition for accepting a new password.
  assign entry_ok = len_full && !ovf_q;
  assign match    = entry_ok && (buf_q == pw_cur);

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    entry_len_d = entry_len_q;
    ovf_d       = ovf_q;
    count_d     = count_q;
    timer_d     = timer_q;
    access_d    = access_q;
    alram_d     = alram_q;
    locked_d    = locked_q;
`ifdef PW_PROG_EN
    pw_d        = pw_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (clear) begin
          buf_d       = '0;
          entry_len_d = '0;
          ovf_d       = 1'b0;
        end else if (enter) begin
          buf_d       = '0;
          entry_len_d = '0;
          ovf_d       = 1'b0;
          if (match) begin
            state_d  = S_OPEN;
            access_d = 1'b1;
            count_d  = '0;
            timer_d  = TMR_W'(OPEN_CYC - 1);
          end else if (int'(count_q) + 1 < MAX_TRIES) begin
            count_d = count_q + CNT_W'(1);
          end else begin
            count_d  = CNT_W'(MAX_TRIES);
            state_d  = S_LOCKOUT;
            alram_d  = 1'b1;
            locked_d = 1'b1;
            timer_d  = TMR_W'(LOCKOUT_CYC - 1);
          end
        end else if (digit_valid) begin
          // A digit past a full entry poisons it rather than shifting.
          if (len_full) begin
            ovf_d = 1'b1;
          end else begin
            buf_d       = (buf_q << DIGIT_W) | PW_W'(digit);
            entry_len_d = entry_len_q + LEN_W'(1);
          end
        end
      end

      S_OPEN: begin
`ifdef PW_PROG_EN
        if (prog_req) begin
          // Timer halts while programming; access stays high.
          state_d = S_PROG;
        end else
`endif
        if (timer_q == '0) begin
          state_d  = S_IDLE;
          access_d = 1'b0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

`ifdef PW_PROG_EN
      S_PROG: begin
        if (clear) begin
          buf_d       = '0;
          entry_len_d = '0;
          ovf_d       = 1'b0;
        end else if (enter) begin
          if (entry_ok) pw_d = buf_q;
          buf_d       = '0;
          entry_len_d = '0;
          ovf_d       = 1'b0;
          state_d     = S_IDLE;
          access_d    = 1'b0;
        end else if (digit_valid) begin
          if (len_full) begin
            ovf_d = 1'b1;
          end else begin
            buf_d       = (buf_q << DIGIT_W) | PW_W'(digit);
            entry_len_d = entry_len_q + LEN_W'(1);
          end
        end
      end
`endif

      S_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d  = S_IDLE;
          alram_d  = 1'b0;
          locked_d = 1'b0;
          count_d  = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      entry_len_q <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      timer_q     <= '0;
      access_q    <= 1'b0;
      alram_q     <= 1'b0;
      locked_q    <= 1'b0;
`ifdef PW_PROG_EN
      pw_q        <= DEFAULT_PW;
`endif
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      entry_len_q <= entry_len_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      access_q    <= access_d;
      alram_q     <= alram_d;
      locked_q    <= locked_d;
`ifdef PW_PROG_EN
      pw_q        <= pw_d;
`endif
    end
  end

  assign access    = access_q;
  assign alram     = alram_q;
  assign locked    = locked_q;
  assign count     = count_q;
  assign entry_len = entry_len_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// tb_keypad_lock_ctrl
//   Scoreboard bench for keypad_lock_ctrl. The driver applies one input vector
//   per cycle on the falling edge, steps a digit-list reference model and queues
//   the outputs expected after the next rising edge. The monitor pops one entry
//   per rising edge and compares every output.
module tb_keypad_lock_ctrl;

  localparam int DIGIT_W     = 4;
  localparam int PW_DIGITS   = 4;
  localparam int MAX_TRIES   = 3;
  localparam int OPEN_CYC    = 4;
  localparam int LOCKOUT_CYC = 8;
  localparam int CNT_W       = $clog2(MAX_TRIES + 1);
  localparam int LEN_W       = $clog2(PW_DIGITS + 1);
  localparam logic [15:0] PW_DEF = 16'h1234;

  logic               clk;
  logic               reset;
  logic               digit_valid;
  logic [DIGIT_W-1:0] digit;
  logic               enter;
  logic               clear;
  logic               prog_req;
  logic               access;
  logic               alram;
  logic               locked;
  logic [CNT_W-1:0]   count;
  logic [LEN_W-1:0]   entry_len;

  keypad_lock_ctrl #(
    .DIGIT_W(DIGIT_W), .PW_DIGITS(PW_DIGITS), .DEFAULT_PW(PW_DEF),
    .MAX_TRIES(MAX_TRIES), .OPEN_CYC(OPEN_CYC), .LOCKOUT_CYC(LOCKOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit),
    .enter(enter), .clear(clear), .prog_req(prog_req),
    .access(access), .alram(alram), .locked(locked),
    .count(count), .entry_len(entry_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic acc;
    logic alr;
    logic lck;
    int   cnt;
    int   len;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model: mode 0 idle, 1 open, 2 lockout, 3 programming.
  int m_mode;
  int m_entry[$];
  bit m_ovf;
  int m_cnt;
  int m_left;   // remaining cycles the open/lockout output stays asserted
  int m_pw[PW_DIGITS];

  task automatic model_reset();
    logic [15:0] p;
    p = PW_DEF;
    m_mode = 0;
    m_entry.delete();
    m_ovf  = 1'b0;
    m_cnt  = 0;
    m_left = 0;
    for (int i = 0; i < PW_DIGITS; i++)
      m_pw[i] = int'((p >> (DIGIT_W * (PW_DIGITS - 1 - i))) & 16'hF);
  endtask

  task automatic model_digit(input int dg);
    if (m_entry.size() == PW_DIGITS) m_ovf = 1'b1;
    else m_entry.push_back(dg);
  endtask

  function automatic bit entry_valid();
    return (m_entry.size() == PW_DIGITS) && !m_ovf;
  endfunction

  task automatic model_step(input bit r, input bit c, input bit e, input bit d,
                            input int dg, input bit pr);
    bit hit;
    if (r) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (c) begin
        m_entry.delete(); m_ovf = 1'b0;
      end else if (e) begin
        hit = entry_valid();
        if (hit) for (int i = 0; i < PW_DIGITS; i++) if (m_entry[i] != m_pw[i]) hit = 1'b0;
        m_entry.delete(); m_ovf = 1'b0;
        if (hit) begin
          m_mode = 1; m_left = OPEN_CYC; m_cnt = 0;
        end else begin
          m_cnt++;
          if (m_cnt >= MAX_TRIES) begin
            m_cnt = MAX_TRIES; m_mode = 2; m_left = LOCKOUT_CYC;
          end
        end
      end else if (d) begin
        model_digit(dg);
      end
    end else if (m_mode == 1) begin
`ifdef PW_PROG_EN
      if (pr) m_mode = 3;
      else begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
`else
      m_left--;
      if (m_left == 0) m_mode = 0;
`endif
    end else if (m_mode == 2) begin
      m_left--;
      if (m_left == 0) begin m_mode = 0; m_cnt = 0; end
    end else begin
      if (c) begin
        m_entry.delete(); m_ovf = 1'b0;
      end else if (e) begin
        if (entry_valid()) for (int i = 0; i < PW_DIGITS; i++) m_pw[i] = m_entry[i];
        m_entry.delete(); m_ovf = 1'b0; m_mode = 0;
      end else if (d) begin
        model_digit(dg);
      end
    end
  endtask

  task automatic step(input bit r, input bit c, input bit e, input bit d,
                      input int dg, input bit pr);
    exp_t x;
    @(negedge clk);
    reset = r; clear = c; enter = e; digit_valid = d;
    digit = DIGIT_W'(dg); prog_req = pr;
    model_step(r, c, e, d, dg, pr);
    x.acc = (m_mode == 1) || (m_mode == 3);
    x.alr = (m_mode == 2);
    x.lck = (m_mode == 2);
    x.cnt = m_cnt;
    x.len = m_entry.size();
    sbq.push_back(x);
  endtask

  task automatic key(input int dg);  step(0, 0, 0, 1, dg, 0); endtask
  task automatic ent();              step(0, 0, 1, 0, 0, 0);  endtask
  task automatic clr();              step(0, 0, 0, 0, 0, 1'b0); step(0, 1, 0, 0, 0, 0); endtask
  task automatic rst1();             step(1, 0, 0, 0, 0, 0);  endtask
  task automatic nop(input int n);   for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0); endtask
  task automatic code(input int a, input int b, input int c, input int d);
    key(a); key(b); key(c); key(d); ent();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL cyc %0d %s: got %0d expected %0d", cyc, nm, act, exp);
    end
  endtask

  // Monitor: one expected vector per rising edge, sampled 1 time unit after it.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        chk("access",    32'(access),    32'(x.acc));
        chk("alram",     32'(alram),     32'(x.alr));
        chk("locked",    32'(locked),    32'(x.lck));
        chk("count",     32'(count),     32'(x.cnt));
        chk("entry_len", 32'(entry_len), 32'(x.len));
      end
    end
  end

  initial begin
    int r, dg;
    bit c, e, d, pr, rs;
    reset = 1'b1; clear = 1'b0; enter = 1'b0; digit_valid = 1'b0;
    digit = '0; prog_req = 1'b0;
    model_reset();

    rst1(); rst1();
    // Correct code opens for OPEN_CYC cycles.
    code(1, 2, 3, 4); nop(6);
    // Three failures lock out; keypad ignored during lockout.
    code(1, 2, 3, 5); code(1, 2, 3, 5); code(1, 2, 3, 5);
    key(1); key(2); key(3); key(4); ent(); nop(6);
    // Two failures then success clears the count.
    code(1, 2, 3, 5); code(1, 2, 3, 5); code(1, 2, 3, 4); nop(6);
    // Overflow is a failure; clear discards a partial entry.
    key(1); key(2); key(3); key(4); key(4); ent();
    key(1); key(2); clr(); code(1, 2, 3, 4); nop(6);
    // Enter on an empty entry fails.
    ent(); nop(1);
    // Reset during lockout.
    code(9, 9, 9, 9); code(9, 9, 9, 9); nop(2); rst1();
    code(1, 2, 3, 4); nop(6);
    // Coincident strobes: clear wins over enter and digit.
    key(1); key(2); step(0, 1, 1, 1, 3, 0); ent(); nop(1);
`ifdef PW_PROG_EN
    code(1, 2, 3, 4); step(0, 0, 0, 0, 0, 1);
    key(9); key(8); key(7); key(6); ent();
    code(1, 2, 3, 4); code(9, 8, 7, 6); nop(6);
`else
    // prog_req has no effect while open in the default build.
    code(1, 2, 3, 4); step(0, 0, 0, 0, 0, 1); key(9); ent(); nop(6);
`endif
    rst1();

    // Randomised traffic, biased toward the stored password so matches occur.
    for (int i = 0; i < 2000; i++) begin
      r  = int'($urandom_range(0, 999));
      rs = (r < 5);
      c  = ($urandom_range(0, 99) < 5);
      e  = ($urandom_range(0, 99) < 12);
      d  = ($urandom_range(0, 99) < 55);
      pr = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 1) == 1) dg = m_pw[m_entry.size() % PW_DIGITS];
      else dg = int'($urandom_range(0, 15));
      step(rs, c, e, d, dg, pr);
    end
    nop(2);

    // Drain: every queued expectation must be consumed within a few cycles.
    repeat (4) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
